// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and its sequential divider leg.
//   - ALU opcode constants used by the result mux (DIV leg is 3'b111)
//   - Divider FSM state encoding
//   - Default operand width for the divider
// No ports: this file only holds types and constants.
// ---------------------------------------------------------------------------
package alu_pkg;

  // Default operand/result width of the divider.
  localparam int ALU_DIV_WIDTH = 8;

  // ALU opcodes, as decoded by the result mux select.
  localparam logic [2:0] OP_NOT = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  // Divider control states.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_DONE = 2'b10
  } divState_t;

endpackage

// File: rtl/alu_divider.sv
// ---------------------------------------------------------------------------
// alu_divider
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// A start accepted in IDLE or DONE captures the operands. Division by zero
// skips the iteration and completes on the next cycle with an all-ones
// quotient and the dividend as remainder.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start        : request a division (looked at only in IDLE or DONE)
//   dividend     : WIDTH-bit unsigned numerator, captured on accept
//   divisor      : WIDTH-bit unsigned denominator, captured on accept
//   quotient     : registered quotient of the last completed operation
//   remainder    : registered remainder of the last completed operation
//   busy         : high while iterating (CALC)
//   done         : one-cycle pulse when results become valid
//   div_by_zero  : registered flag for the last completed operation
// ---------------------------------------------------------------------------
module alu_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  divState_t        r_state;
  divState_t        w_stateNext;

  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quoWork;
  logic [WIDTH:0]   r_rem;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic             w_accept;
  logic             w_divZero;
  logic             w_lastStep;
  logic [WIDTH:0]   w_shifted;
  logic             w_qBit;
  logic [WIDTH:0]   w_remNext;
  logic [WIDTH-1:0] w_quoNext;
  logic             w_busyNext;
  logic             w_doneNext;

  // A new request is only honoured when no iteration is in flight, so a
  // start pulse during CALC leaves the captured operands untouched.
  assign w_accept   = start && ((r_state == DIV_IDLE) || (r_state == DIV_DONE));
  assign w_divZero  = (divisor == '0);
  assign w_lastStep = (r_cnt == LAST_STEP);

  // One restoring step: shift the partial remainder left, pull in the next
  // dividend bit, and subtract the divisor if it fits. The extra top bit of
  // the partial remainder keeps the compare exact even when the shifted
  // value exceeds WIDTH bits.
  assign w_shifted = (r_rem << 1) | (WIDTH + 1)'(r_dvd[WIDTH-1]);
  assign w_qBit    = (w_shifted >= {1'b0, r_dvs});
  assign w_remNext = w_qBit ? (w_shifted - {1'b0, r_dvs}) : w_shifted;
  assign w_quoNext = (r_quoWork << 1) | WIDTH'(w_qBit);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic. DONE behaves like IDLE for a new request so that
  // back-to-back operations need no idle cycle in between.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      DIV_IDLE: begin
        if (w_accept) begin
          w_stateNext = w_divZero ? DIV_DONE : DIV_CALC;
        end
      end
      DIV_CALC: begin
        if (w_lastStep) begin
          w_stateNext = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (w_accept) begin
          w_stateNext = w_divZero ? DIV_DONE : DIV_CALC;
        end else begin
          w_stateNext = DIV_IDLE;
        end
      end
      default: begin
        w_stateNext = DIV_IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state. busy and done are registered from
  // these so both line up exactly with the state they describe.
  always_comb begin
    w_busyNext = (w_stateNext == DIV_CALC);
    w_doneNext = (w_stateNext == DIV_DONE);
  end

  // Datapath and result registers. The visible quotient/remainder only
  // change on completion; the running quotient lives in r_quoWork so a
  // later operation can iterate without disturbing the previous result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_quoWork   <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_busy <= w_busyNext;
      r_done <= w_doneNext;
      if (w_accept) begin
        if (w_divZero) begin
          r_quotient  <= '1;
          r_remainder <= dividend;
          r_dbz       <= 1'b1;
        end else begin
          r_dvd     <= dividend;
          r_dvs     <= divisor;
          r_quoWork <= '0;
          r_rem     <= '0;
          r_cnt     <= '0;
        end
      end else if (r_state == DIV_CALC) begin
        r_dvd     <= r_dvd << 1;
        r_rem     <= w_remNext;
        r_quoWork <= w_quoNext;
        r_cnt     <= r_cnt + 1'b1;
        if (w_lastStep) begin
          r_quotient  <= w_quoNext;
          r_remainder <= w_remNext[WIDTH-1:0];
          r_dbz       <= 1'b0;
        end
      end
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule
